// File: rtl/sample_sdiv_14s_8u_seq_if.sv
// sample_sdiv_14s_8u_seq_if: ap_start/ap_done handshake plus operand and result bus of the divider.
// Ports:
//   ap_start/ap_ready/ap_idle/ap_done : block-level handshake
//   din0 (14b signed dividend), din1 (8b unsigned divisor)
//   dout (14b signed quotient), rem (9b signed remainder), dbz (divide-by-zero flag)
interface sample_sdiv_14s_8u_seq_if;
  logic ap_start;
  logic ap_ready;
  logic ap_idle;
  logic ap_done;
  logic [13:0] din0;
  logic [7:0] din1;
  logic [13:0] dout;
  logic [8:0] rem;
  logic dbz;
  modport master (
    output ap_start, din0, din1,
    input  ap_ready, ap_idle, ap_done, dout, rem, dbz
  );
  modport slave (
    input  ap_start, din0, din1,
    output ap_ready, ap_idle, ap_done, dout, rem, dbz
  );
endinterface

// File: rtl/sample_sdiv_14s_8u_seq.sv
// sample_sdiv_14s_8u_seq: sequential 14b signed / 8b unsigned restoring divider, one quotient bit per clock.
// Ports:
//   ap_clk   : clock, rising edge
//   ap_rst_n : asynchronous active-low reset
//   bus      : slave side of the handshake/operand/result interface
// An op accepted at edge E0 iterates on E1..E14 and registers the results on E15 with ap_done
// high for the following cycle; quotient and remainder truncate toward zero.
module sample_sdiv_14s_8u_seq #(
  parameter int ID         = 1,
  parameter int din0_WIDTH = 14,
  parameter int din1_WIDTH = 8,
  parameter int dout_WIDTH = 14
) (
  input logic ap_clk,
  input logic ap_rst_n,
  sample_sdiv_14s_8u_seq_if.slave bus
);
  if (din0_WIDTH != 14 || din1_WIDTH != 8 || dout_WIDTH != 14 || ID < 0) begin : g_param_check
    $error("sample_sdiv_14s_8u_seq supports only the 14/8/14 configuration");
  end
  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
  state_t state, state_nxt;
  logic [din0_WIDTH-1:0] mag;
  logic [din1_WIDTH-1:0] div;
  logic [8:0] r;
  logic [8:0] r_sh;
  logic [8:0] r_sub;
  logic q_bit;
  logic [3:0] cnt;
  logic neg;
  logic zdiv;
  logic accept;
  logic done;
  logic [dout_WIDTH-1:0] dout;
  logic [8:0] rem;
  logic dbz;
  assign accept = (state == IDLE) && bus.ap_start;
  // the partial remainder stays below div (<= 255), so its low 8 bits plus the next
  // dividend bit always fit the 9-bit trial value
  assign r_sh  = {r[7:0], mag[din0_WIDTH-1]};
  assign q_bit = r_sh >= {1'b0, div};
  assign r_sub = q_bit ? r_sh - {1'b0, div} : r_sh;
  assign bus.ap_idle  = state == IDLE;
  assign bus.ap_ready = accept;
  assign bus.ap_done  = done;
  assign bus.dout     = dout;
  assign bus.rem      = rem;
  assign bus.dbz      = dbz;
  always_comb begin
    state_nxt = state;
    if (accept) state_nxt = CALC;
    if (state == CALC && cnt == 4'd13) state_nxt = FIX;
    if (state == FIX) state_nxt = IDLE;
  end
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) state <= IDLE;
    else state <= state_nxt;
  end
  // mag doubles as the quotient shift register: dividend bits leave at the top while
  // quotient bits enter at the bottom, so after 14 shifts it holds the unsigned quotient
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      mag  <= '0;
      div  <= '0;
      r    <= '0;
      cnt  <= '0;
      neg  <= 1'b0;
      zdiv <= 1'b0;
      done <= 1'b0;
      dout <= '0;
      rem  <= '0;
      dbz  <= 1'b0;
    end else begin
      done <= state == FIX;
      if (accept) begin
        neg  <= bus.din0[din0_WIDTH-1];
        mag  <= bus.din0[din0_WIDTH-1] ? -bus.din0 : bus.din0;
        div  <= bus.din1;
        zdiv <= bus.din1 == '0;
        r    <= '0;
        cnt  <= '0;
      end
      if (state == CALC) begin
        r   <= r_sub;
        mag <= {mag[din0_WIDTH-2:0], q_bit};
        cnt <= cnt + 4'd1;
      end
      if (state == FIX) begin
        dout <= zdiv ? '0 : neg ? -mag : mag;
        rem  <= zdiv ? '0 : neg ? -r : r;
        dbz  <= zdiv;
      end
    end
  end
endmodule

// File: tb/tb_sample_sdiv_14s_8u_seq.sv
// tb_sample_sdiv_14s_8u_seq: directed and randomized checks of the divider against a C-semantics division model.
module tb_sample_sdiv_14s_8u_seq;
  logic ap_clk = 1'b0;
  logic ap_rst_n;
  int checks = 0;
  int errors = 0;
  sample_sdiv_14s_8u_seq_if bus ();
  sample_sdiv_14s_8u_seq #(.ID(1), .din0_WIDTH(14), .din1_WIDTH(8), .dout_WIDTH(14)) dut (
    .ap_clk(ap_clk),
    .ap_rst_n(ap_rst_n),
    .bus(bus)
  );
  always #5 ap_clk = ~ap_clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // result packed as {dbz, rem[8:0], dout[13:0]}
  function automatic logic [23:0] ref_div(input logic [13:0] a, input logic [7:0] b);
    int sa, sb, q, r;
    logic [13:0] q14;
    logic [8:0] r9;
    sa = $signed(a);
    sb = b;
    if (sb == 0) return {1'b1, 9'd0, 14'd0};
    q = sa / sb;
    r = sa % sb;
    q14 = q[13:0];
    r9 = r[8:0];
    return {1'b0, r9, q14};
  endfunction
  int m_cnt;
  logic m_done;
  logic [23:0] m_pend, m_res;
  always @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      m_cnt <= 0;
      m_done <= 1'b0;
      m_pend <= '0;
      m_res <= '0;
    end else begin
      m_done <= 1'b0;
      if (m_cnt == 0) begin
        if (bus.ap_start) begin
          m_pend <= ref_div(bus.din0, bus.din1);
          m_cnt <= 15;
        end
      end else begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) begin
          m_done <= 1'b1;
          m_res <= m_pend;
        end
      end
    end
  end
  always @(negedge ap_clk) begin
    chk("idle", 32'(bus.ap_idle), 32'(m_cnt == 0));
    chk("ready", 32'(bus.ap_ready), 32'(bus.ap_start && m_cnt == 0));
    chk("done", 32'(bus.ap_done), 32'(m_done));
    chk("dout", 32'(bus.dout), 32'(m_res[13:0]));
    chk("rem", 32'(bus.rem), 32'(m_res[22:14]));
    chk("dbz", 32'(bus.dbz), 32'(m_res[23]));
  end
  task automatic step();
    @(posedge ap_clk);
    #1;
  endtask
  task automatic scramble();
    bus.din0 = 14'($urandom);
    bus.din1 = 8'($urandom);
  endtask
  task automatic wait_done(output int n);
    n = 0;
    while (!bus.ap_done && n < 40) begin
      step();
      scramble();
      n++;
    end
  endtask
  task automatic run_op(input int a, input int b, input logic [13:0] eq, input logic [8:0] er, input logic ez);
    int n;
    bus.ap_start = 1'b1;
    bus.din0 = a[13:0];
    bus.din1 = b[7:0];
    step();
    bus.ap_start = 1'b0;
    scramble();
    wait_done(n);
    chk("latency", 32'(n), 32'd15);
    chk("lit_dout", 32'(bus.dout), 32'(eq));
    chk("lit_rem", 32'(bus.rem), 32'(er));
    chk("lit_dbz", 32'(bus.dbz), 32'(ez));
  endtask
  initial begin
    int rdy[$];
    int n, dn;
    int ea[4] = '{-8192, 8191, 0, -1};
    int eb[3] = '{0, 1, 255};
    ap_rst_n = 1'b0;
    bus.ap_start = 1'b0;
    bus.din0 = '0;
    bus.din1 = '0;
    repeat (3) step();
    chk("rst_dout", 32'(bus.dout), 32'd0);
    chk("rst_rem", 32'(bus.rem), 32'd0);
    chk("rst_dbz", 32'(bus.dbz), 32'd0);
    chk("rst_done", 32'(bus.ap_done), 32'd0);
    chk("rst_idle", 32'(bus.ap_idle), 32'd1);
    ap_rst_n = 1'b1;
    step();
    run_op(100, 7, 14'd14, 9'd2, 1'b0);
    run_op(-100, 7, 14'h3FF2, 9'h1FE, 1'b0);
    run_op(-8192, 1, 14'h2000, 9'd0, 1'b0);
    run_op(8191, 255, 14'd32, 9'd31, 1'b0);
    run_op(5, 200, 14'd0, 9'd5, 1'b0);
    run_op(1234, 0, 14'd0, 9'd0, 1'b1);
    for (int i = 0; i < 48; i++) begin
      bus.ap_start = 1'b1;
      scramble();
      #1;
      if (bus.ap_ready) rdy.push_back(i);
      step();
    end
    bus.ap_start = 1'b0;
    chk("ready_pulses", 32'(rdy.size()), 32'd3);
    if (rdy.size() == 3) begin
      chk("ready_e0", 32'(rdy[0]), 32'd0);
      chk("ready_e16", 32'(rdy[1]), 32'd16);
      chk("ready_e32", 32'(rdy[2]), 32'd32);
    end
    repeat (20) step();
    run_op(100, 7, 14'd14, 9'd2, 1'b0);
    bus.ap_start = 1'b1;
    bus.din0 = 14'd77;
    bus.din1 = 8'd3;
    step();
    bus.ap_start = 1'b0;
    repeat (7) step();
    #2 ap_rst_n = 1'b0;
    #1;
    chk("abort_dout", 32'(bus.dout), 32'd0);
    chk("abort_rem", 32'(bus.rem), 32'd0);
    chk("abort_idle", 32'(bus.ap_idle), 32'd1);
    step();
    step();
    ap_rst_n = 1'b1;
    dn = 0;
    repeat (20) begin
      step();
      if (bus.ap_done) dn++;
    end
    chk("abort_no_done", 32'(dn), 32'd0);
    run_op(100, 7, 14'd14, 9'd2, 1'b0);
    for (int k = 0; k < 150; k++) begin
      repeat ($urandom_range(0, 2)) step();
      bus.ap_start = 1'b1;
      bus.din0 = ($urandom_range(0, 3) == 0) ? 14'(ea[$urandom_range(0, 3)]) : 14'($urandom);
      bus.din1 = ($urandom_range(0, 3) == 0) ? 8'(eb[$urandom_range(0, 2)]) : 8'($urandom);
      step();
      bus.ap_start = 1'b0;
      scramble();
      wait_done(n);
      chk("rand_latency", 32'(n), 32'd15);
    end
    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sample_sdiv_14s_8u_seq.md
# sample_sdiv_14s_8u_seq

Sequential signed-by-unsigned divider that inverts the 8-bit-unsigned × 14-bit-signed multiply used in `sample`. It divides a 14-bit signed dividend by an 8-bit unsigned divisor and returns a 14-bit signed quotient and a 9-bit signed remainder, using C truncation semantics. It uses radix-2 restoring division at one quotient bit per clock, with an ap_start/ap_done block-level handshake. It sits beside the multiply datapath where a value must be de-scaled by an unsigned 8-bit factor.

## Interface
- ID, 1, instance identifier; no functional effect
- din0_WIDTH, 14, dividend width; fixed at 14
- din1_WIDTH, 8, divisor width; fixed at 8
- dout_WIDTH, 14, quotient width; fixed at 14
- ap_clk  in  1  sole clock; all state updates on the rising edge
- ap_rst_n  in  1  reset, asynchronous, active-low
- ap_start  in  1  request; sampled only while idle
- ap_ready  out  1  combinational, equals ap_start & ap_idle; operands are captured on that edge
- ap_idle  out  1  high when no division is in progress
- ap_done  out  1  one-cycle pulse; dout, rem and dbz are valid
- din0  in  14  signed dividend
- din1  in  8  unsigned divisor
- dout  out  14  signed quotient, registered and held until the next ap_done
- rem  out  9  signed remainder, registered and held
- dbz  out  1  divide-by-zero flag, registered, valid with ap_done

## Operation
- FSM has 3 states:
  - IDLE -> CALC when ap_start=1.
  - CALC -> FIX after 14 iterations.
  - FIX -> IDLE.
- IDLE accept:
  - Latch neg = din0[13] and mag = |din0| as a 14-bit unsigned value (-8192 yields 8192).
  - Latch div = din1, and clear the 9-bit partial remainder and the iteration counter.
  - Latch zdiv = (din1 == 0).
- CALC, each cycle (MSB first):
  - Shift the remainder left and bring in the next mag bit.
  - If remainder ≥ div, subtract div and set the quotient bit to 1; otherwise set it to 0.
  - Increment the counter.
- FIX:
  - dout = neg ? −q : q, truncated to 14 bits.
  - rem = neg ? −r : r, as a 9-bit signed value. Remainder sign follows the dividend, and |rem| < divisor.
  - If zdiv: dout = 0, rem = 0, dbz = 1. Otherwise dbz = 0.
  - Pulse ap_done in the following cycle.
- No overflow is possible. The largest quotient magnitude is 8192, reached only for -8192/1, which is representable.
- din0 and din1 are ignored outside the accept edge. They may change freely during CALC and FIX.
- ap_start low in IDLE: hold state. Outputs keep their last values.

## Timing
- Reset (asynchronous assert, synchronous release effect):
  - State = IDLE; dout = 0, rem = 0, dbz = 0, ap_done = 0.
  - Internal registers are cleared.
  - ap_idle = 1.
- Accept edge E0 is the rising edge with ap_start=1 while in IDLE.
  - ap_ready is high in the cycle before E0.
  - ap_idle is low from E0 until the FIX edge.
- Edges E1–E14 perform the iterations. Edge E15 is FIX: it registers the outputs, returns the FSM to IDLE and sets ap_done.
- ap_done is high for exactly the one cycle between E15 and E16. During that cycle ap_idle=1.
- The next op can be accepted at E16 at the earliest. Sustained throughput is one division per 16 cycles with ap_start held high.
- Latency is fixed and independent of operands, including divide-by-zero.
- Reset asserted mid-operation:
  - Abort immediately; no ap_done for the aborted op.
  - Outputs go to their reset values.
- ap_start deasserted during CALC has no effect. The operation completes.

## Test plan
- 100 / 7:
  - Start at E0 -> ap_done pulse between E15 and E16.
  - dout=14, rem=2, dbz=0.
- −100 / 7 -> dout=−14 (14'h3FF2), rem=−2 (9'h1FE).
- Boundaries:
  - −8192 / 1 -> dout=−8192 (14'h2000), rem=0.
  - 8191 / 255 -> dout=32, rem=31.
  - 5 / 200 -> dout=0, rem=5.
- 1234 / 0 -> dbz=1, dout=0, rem=0, with ap_done at the same cycle position as a normal op.
- ap_start held high with operands changed every cycle -> ap_ready pulses at E0, E16, E32. Each result matches only the operands present at its accept edge.
- ap_rst_n pulsed low at E7 of an op -> outputs go to 0 immediately, and no ap_done follows. A subsequent 100/7 then completes normally with dout=14, rem=2.
